// File: rtl/pi1_rrarb.sv
// Round-robin arbiter letting MASTERCOUNT PI1 masters share one PI1 slave.
// Define PI1_RRARB_TIMEOUT_EN to add a watchdog that force-completes stuck transactions.
module pi1_rrarb #(
    parameter  int unsigned MASTERCOUNT = 2,
    parameter  int unsigned ARCHBITSZ   = 32,
    parameter  int unsigned TIMEOUT     = 1024,
    localparam int unsigned ADDRBITSZ   = ARCHBITSZ - $clog2(ARCHBITSZ/8),
    localparam int unsigned SELBITSZ    = ARCHBITSZ/8,
    localparam int unsigned GW          = (MASTERCOUNT > 1) ? $clog2(MASTERCOUNT) : 1
) (
    input  logic                            clk_i,
    input  logic                            rst_n,
    input  logic [2*MASTERCOUNT-1:0]        m_op_i,
    input  logic [ADDRBITSZ*MASTERCOUNT-1:0] m_addr_i,
    input  logic [ARCHBITSZ*MASTERCOUNT-1:0] m_data_i,
    input  logic [SELBITSZ*MASTERCOUNT-1:0] m_sel_i,
    output logic [ARCHBITSZ-1:0]            m_data_o,
    output logic [MASTERCOUNT-1:0]          m_rdy_o,
    output logic [1:0]                      s_op_o,
    output logic [ADDRBITSZ-1:0]            s_addr_o,
    output logic [ARCHBITSZ-1:0]            s_data_o,
    output logic [SELBITSZ-1:0]             s_sel_o,
    input  logic [ARCHBITSZ-1:0]            s_data_i,
    input  logic                            s_rdy_i,
    output logic                            err_o,
    output logic [GW-1:0]                   gnt_o
);

    if (MASTERCOUNT < 2 || MASTERCOUNT > 8 || TIMEOUT < 2) begin : g_param_check
        $error("pi1_rrarb: unsupported parameter set");
    end

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    state_t                 state;
    logic [GW-1:0]          ptr;
    logic [GW-1:0]          gnt;
    logic [1:0]             hold_op;
    logic [ADDRBITSZ-1:0]   hold_addr;
    logic [ARCHBITSZ-1:0]   hold_data;
    logic [SELBITSZ-1:0]    hold_sel;

    logic                   req_any;
    logic [GW-1:0]          pick;
    logic [GW-1:0]          ptr_next;
    logic [MASTERCOUNT-1:0] gnt_onehot;

    // First requester at or after ptr, wrapping around the master list.
    always_comb begin
        int unsigned idx;
        req_any = 1'b0;
        pick    = '0;
        idx     = 0;
        for (int unsigned i = 0; i < MASTERCOUNT; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= MASTERCOUNT)
                idx = idx - MASTERCOUNT;
            if (!req_any && m_op_i[idx*2 +: 2] != 2'b00) begin
                req_any = 1'b1;
                pick    = GW'(idx);
            end
        end
    end

    always_comb begin
        ptr_next   = (gnt == GW'(MASTERCOUNT-1)) ? '0 : gnt + 1'b1;
        gnt_onehot = {{(MASTERCOUNT-1){1'b0}}, 1'b1} << gnt;
    end

    // The slave only ever sees the latched command, and only while in ISSUE.
    assign s_op_o   = (state == ISSUE) ? hold_op : 2'b00;
    assign s_addr_o = hold_addr;
    assign s_data_o = hold_data;
    assign s_sel_o  = hold_sel;
    assign gnt_o    = gnt;

`ifdef PI1_RRARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT);
    logic [CW-1:0] wdog;
`else
    assign err_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt       <= '0;
            hold_op   <= 2'b00;
            hold_addr <= '0;
            hold_data <= '0;
            hold_sel  <= '0;
            m_data_o  <= '0;
            m_rdy_o   <= '0;
`ifdef PI1_RRARB_TIMEOUT_EN
            err_o     <= 1'b0;
            wdog      <= '0;
`endif
        end else begin
            m_rdy_o <= '0;
`ifdef PI1_RRARB_TIMEOUT_EN
            err_o   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (req_any) begin
                        gnt       <= pick;
                        hold_op   <= m_op_i[pick*2 +: 2];
                        hold_addr <= m_addr_i[pick*ADDRBITSZ +: ADDRBITSZ];
                        hold_data <= m_data_i[pick*ARCHBITSZ +: ARCHBITSZ];
                        hold_sel  <= m_sel_i[pick*SELBITSZ +: SELBITSZ];
                        state     <= ISSUE;
`ifdef PI1_RRARB_TIMEOUT_EN
                        wdog      <= '0;
`endif
                    end
                end
                ISSUE: begin
                    if (s_rdy_i)
                        state <= RESP;
`ifdef PI1_RRARB_TIMEOUT_EN
                    // Watchdog overrides a same-cycle accept: the transaction is dropped.
                    wdog <= wdog + 1'b1;
                    if (wdog == CW'(TIMEOUT-1)) begin
                        m_data_o <= '0;
                        m_rdy_o  <= gnt_onehot;
                        err_o    <= 1'b1;
                        ptr      <= ptr_next;
                        state    <= IDLE;
                    end
`endif
                end
                RESP: begin
                    if (s_rdy_i) begin
                        m_data_o <= s_data_i;
                        m_rdy_o  <= gnt_onehot;
                        ptr      <= ptr_next;
                        state    <= IDLE;
                    end
`ifdef PI1_RRARB_TIMEOUT_EN
                    else if (wdog == CW'(TIMEOUT-1)) begin
                        m_data_o <= '0;
                        m_rdy_o  <= gnt_onehot;
                        err_o    <= 1'b1;
                        ptr      <= ptr_next;
                        state    <= IDLE;
                    end
                    wdog <= wdog + 1'b1;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pi1_rrarb.sv
// Directed self-checking bench for pi1_rrarb with four masters and a 32-bit bus.
// Timeout expectations follow PI1_RRARB_TIMEOUT_EN.
module tb_pi1_rrarb;

    localparam int unsigned MC = 4;
    localparam int unsigned AW = 30;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = 4;

    logic              clk_i = 1'b0;
    logic              rst_n = 1'b0;
    logic [2*MC-1:0]   m_op_i = '0;
    logic [AW*MC-1:0]  m_addr_i = '0;
    logic [DW*MC-1:0]  m_data_i = '0;
    logic [SW*MC-1:0]  m_sel_i = '0;
    logic [DW-1:0]     m_data_o;
    logic [MC-1:0]     m_rdy_o;
    logic [1:0]        s_op_o;
    logic [AW-1:0]     s_addr_o;
    logic [DW-1:0]     s_data_o;
    logic [SW-1:0]     s_sel_o;
    logic [DW-1:0]     s_data_i = '0;
    logic              s_rdy_i = 1'b0;
    logic              err_o;
    logic [1:0]        gnt_o;

    int checks = 0;
    int failures = 0;

    pi1_rrarb #(
        .MASTERCOUNT(MC),
        .ARCHBITSZ(DW),
        .TIMEOUT(16)
    ) dut (
        .clk_i(clk_i),
        .rst_n(rst_n),
        .m_op_i(m_op_i),
        .m_addr_i(m_addr_i),
        .m_data_i(m_data_i),
        .m_sel_i(m_sel_i),
        .m_data_o(m_data_o),
        .m_rdy_o(m_rdy_o),
        .s_op_o(s_op_o),
        .s_addr_o(s_addr_o),
        .s_data_o(s_data_o),
        .s_sel_o(s_sel_o),
        .s_data_i(s_data_i),
        .s_rdy_i(s_rdy_i),
        .err_o(err_o),
        .gnt_o(gnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_req(input int m, input logic [1:0] op, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [SW-1:0] s);
        m_op_i[m*2 +: 2]    = op;
        m_addr_i[m*AW +: AW] = a;
        m_data_i[m*DW +: DW] = d;
        m_sel_i[m*SW +: SW]  = s;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        m_op_i   = '0;
        m_addr_i = '0;
        m_data_i = '0;
        m_sel_i  = '0;
        s_rdy_i  = 1'b0;
        s_data_i = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (s_op_o !== 2'b00) begin failures++; $display("FAIL reset_s_op got=%b exp=00", s_op_o); end
        checks++; if (m_rdy_o !== 4'b0000) begin failures++; $display("FAIL reset_m_rdy got=%b exp=0000", m_rdy_o); end
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_o); end
        checks++; if (m_data_o !== 32'h0) begin failures++; $display("FAIL reset_m_data got=%h exp=0", m_data_o); end
        checks++; if (gnt_o !== 2'd0) begin failures++; $display("FAIL reset_gnt got=%0d exp=0", gnt_o); end
        checks++; if (s_addr_o !== 30'h0) begin failures++; $display("FAIL reset_s_addr got=%h exp=0", s_addr_o); end
        // Idle with no requester: nothing leaves the arbiter.
        tick();
        checks++; if (s_op_o !== 2'b00 || m_rdy_o !== 4'b0000) begin failures++; $display("FAIL idle_quiet got op=%b rdy=%b exp op=00 rdy=0000", s_op_o, m_rdy_o); end
    endtask

    task automatic test_single_read();
        do_reset();
        s_rdy_i  = 1'b1;
        s_data_i = 32'hDEADBEEF;
        set_req(0, 2'b10, 30'h100, 32'h0, 4'hF);
        tick();
        checks++; if (gnt_o !== 2'd0) begin failures++; $display("FAIL sr_gnt got=%0d exp=0", gnt_o); end
        checks++; if (s_op_o !== 2'b10 || s_addr_o !== 30'h100) begin failures++; $display("FAIL sr_issue got op=%b addr=%h exp op=10 addr=100", s_op_o, s_addr_o); end
        checks++; if (m_rdy_o !== 4'b0000) begin failures++; $display("FAIL sr_rdy_early1 got=%b exp=0000", m_rdy_o); end
        tick();
        checks++; if (s_op_o !== 2'b00 || m_rdy_o !== 4'b0000) begin failures++; $display("FAIL sr_resp got op=%b rdy=%b exp op=00 rdy=0000", s_op_o, m_rdy_o); end
        tick();
        checks++; if (m_rdy_o !== 4'b0001) begin failures++; $display("FAIL sr_rdy got=%b exp=0001", m_rdy_o); end
        checks++; if (m_data_o !== 32'hDEADBEEF) begin failures++; $display("FAIL sr_data got=%h exp=deadbeef", m_data_o); end
        // ptr is now 1: with masters 0 and 1 both requesting, 1 wins.
        set_req(0, 2'b10, 30'h104, 32'h0, 4'hF);
        set_req(1, 2'b10, 30'h200, 32'h0, 4'hF);
        s_data_i = 32'h11112222;
        tick();
        checks++; if (m_rdy_o !== 4'b0000) begin failures++; $display("FAIL sr_rdy_one_cycle got=%b exp=0000", m_rdy_o); end
        checks++; if (gnt_o !== 2'd1 || s_addr_o !== 30'h200) begin failures++; $display("FAIL sr_ptr_gnt got gnt=%0d addr=%h exp gnt=1 addr=200", gnt_o, s_addr_o); end
        checks++; if (m_data_o !== 32'hDEADBEEF) begin failures++; $display("FAIL sr_data_hold got=%h exp=deadbeef", m_data_o); end
        tick();
        tick();
        checks++; if (m_rdy_o !== 4'b0010 || m_data_o !== 32'h11112222) begin failures++; $display("FAIL sr_m1_done got rdy=%b data=%h exp rdy=0010 data=11112222", m_rdy_o, m_data_o); end
        set_req(1, 2'b00, 30'h0, 32'h0, 4'h0);
        tick();
        checks++; if (gnt_o !== 2'd0 || s_addr_o !== 30'h104) begin failures++; $display("FAIL sr_wrap_gnt got gnt=%0d addr=%h exp gnt=0 addr=104", gnt_o, s_addr_o); end
        tick();
        tick();
        checks++; if (m_rdy_o !== 4'b0001) begin failures++; $display("FAIL sr_m0_done got=%b exp=0001", m_rdy_o); end
        set_req(0, 2'b00, 30'h0, 32'h0, 4'h0);
    endtask

    task automatic test_contention();
        logic [1:0] order [5];
        order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        do_reset();
        s_rdy_i  = 1'b1;
        s_data_i = 32'hC0DE0000;
        for (int m = 0; m < 4; m++)
            set_req(m, 2'b10, 30'(32'h300 + m), 32'h0, 4'hF);
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++; if (gnt_o !== order[k] || s_op_o !== 2'b10) begin failures++; $display("FAIL cont_gnt%0d got gnt=%0d op=%b exp gnt=%0d op=10", k, gnt_o, s_op_o, order[k]); end
            tick();
            checks++; if (m_rdy_o !== 4'b0000) begin failures++; $display("FAIL cont_quiet%0d got=%b exp=0000", k, m_rdy_o); end
            tick();
            checks++; if (m_rdy_o !== (4'b0001 << order[k])) begin failures++; $display("FAIL cont_rdy%0d got=%b exp=%b", k, m_rdy_o, 4'b0001 << order[k]); end
        end
        m_op_i = '0;
    endtask

    task automatic test_stall();
        do_reset();
        s_rdy_i = 1'b0;
        set_req(2, 2'b01, 30'h2AB, 32'h12345678, 4'hA);
        tick();
        checks++; if (gnt_o !== 2'd2) begin failures++; $display("FAIL st_gnt got=%0d exp=2", gnt_o); end
        // Changes after grant must not reach the slave.
        set_req(2, 2'b10, 30'h3FF, 32'h0, 4'h1);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (s_op_o !== 2'b01 || s_addr_o !== 30'h2AB || s_data_o !== 32'h12345678 || s_sel_o !== 4'hA) begin
                failures++;
                $display("FAIL st_hold%0d got op=%b addr=%h data=%h sel=%h exp op=01 addr=2ab data=12345678 sel=a", c, s_op_o, s_addr_o, s_data_o, s_sel_o);
            end
            if (c < 4) tick();
        end
        s_rdy_i = 1'b1;
        tick();
        checks++; if (s_op_o !== 2'b00 || m_rdy_o !== 4'b0000) begin failures++; $display("FAIL st_accept got op=%b rdy=%b exp op=00 rdy=0000", s_op_o, m_rdy_o); end
        tick();
        checks++; if (m_rdy_o !== 4'b0100) begin failures++; $display("FAIL st_done got=%b exp=0100", m_rdy_o); end
        m_op_i = '0;
    endtask

    task automatic test_reset_mid_resp();
        do_reset();
        s_rdy_i = 1'b1;
        set_req(2, 2'b10, 30'h10, 32'h0, 4'hF);
        tick(); tick(); tick();
        checks++; if (m_rdy_o !== 4'b0100) begin failures++; $display("FAIL rm_pre got=%b exp=0100", m_rdy_o); end
        m_op_i = '0;
        set_req(3, 2'b10, 30'h20, 32'h0, 4'hF);
        tick();
        checks++; if (gnt_o !== 2'd3) begin failures++; $display("FAIL rm_gnt3 got=%0d exp=3", gnt_o); end
        tick();
        rst_n = 1'b0;
        tick();
        checks++; if (m_rdy_o !== 4'b0000 || s_op_o !== 2'b00 || gnt_o !== 2'd0) begin failures++; $display("FAIL rm_reset got rdy=%b op=%b gnt=%0d exp rdy=0000 op=00 gnt=0", m_rdy_o, s_op_o, gnt_o); end
        rst_n = 1'b1;
        set_req(0, 2'b10, 30'h30, 32'h0, 4'hF);
        tick();
        checks++; if (m_rdy_o !== 4'b0000) begin failures++; $display("FAIL rm_no_pulse got=%b exp=0000", m_rdy_o); end
        checks++; if (gnt_o !== 2'd0 || s_addr_o !== 30'h30) begin failures++; $display("FAIL rm_regrant got gnt=%0d addr=%h exp gnt=0 addr=30", gnt_o, s_addr_o); end
        tick(); tick();
        checks++; if (m_rdy_o !== 4'b0001) begin failures++; $display("FAIL rm_m0_done got=%b exp=0001", m_rdy_o); end
        set_req(0, 2'b00, 30'h0, 32'h0, 4'h0);
        tick();
        checks++; if (gnt_o !== 2'd3 || s_addr_o !== 30'h20) begin failures++; $display("FAIL rm_m3_gnt got gnt=%0d addr=%h exp gnt=3 addr=20", gnt_o, s_addr_o); end
        tick(); tick();
        checks++; if (m_rdy_o !== 4'b1000) begin failures++; $display("FAIL rm_m3_done got=%b exp=1000", m_rdy_o); end
        m_op_i = '0;
    endtask

    task automatic test_rw_swap();
        do_reset();
        s_rdy_i  = 1'b1;
        s_data_i = 32'hAA;
        set_req(1, 2'b11, 30'h40, 32'h55, 4'h1);
        tick();
        checks++; if (gnt_o !== 2'd1 || s_op_o !== 2'b11 || s_data_o !== 32'h55) begin failures++; $display("FAIL rw_issue got gnt=%0d op=%b data=%h exp gnt=1 op=11 data=55", gnt_o, s_op_o, s_data_o); end
        tick(); tick();
        checks++; if (m_rdy_o !== 4'b0010 || m_data_o !== 32'hAA) begin failures++; $display("FAIL rw_done got rdy=%b data=%h exp rdy=0010 data=aa", m_rdy_o, m_data_o); end
        m_op_i = '0;
    endtask

    // Runs right after test_rw_swap so m_data_o starts at 0xAA, exposing the forced zero.
    task automatic test_timeout();
        s_rdy_i = 1'b0;
        set_req(0, 2'b10, 30'h50, 32'h0, 4'hF);
        tick();
        checks++; if (gnt_o !== 2'd0 || s_op_o !== 2'b10) begin failures++; $display("FAIL to_gnt got gnt=%0d op=%b exp gnt=0 op=10", gnt_o, s_op_o); end
`ifdef PI1_RRARB_TIMEOUT_EN
        for (int c = 1; c < 16; c++) begin
            tick();
            checks++; if (err_o !== 1'b0 || m_rdy_o !== 4'b0000) begin failures++; $display("FAIL to_early%0d got err=%b rdy=%b exp err=0 rdy=0000", c, err_o, m_rdy_o); end
        end
        tick();
        checks++; if (err_o !== 1'b1 || m_rdy_o !== 4'b0001 || m_data_o !== 32'h0) begin failures++; $display("FAIL to_fire got err=%b rdy=%b data=%h exp err=1 rdy=0001 data=0", err_o, m_rdy_o, m_data_o); end
        checks++; if (s_op_o !== 2'b00) begin failures++; $display("FAIL to_sop got=%b exp=00", s_op_o); end
        m_op_i = '0;
        tick();
        checks++; if (err_o !== 1'b0 || m_rdy_o !== 4'b0000) begin failures++; $display("FAIL to_pulse got err=%b rdy=%b exp err=0 rdy=0000", err_o, m_rdy_o); end
`else
        for (int c = 1; c <= 40; c++) begin
            tick();
            checks++; if (err_o !== 1'b0 || m_rdy_o !== 4'b0000 || s_op_o !== 2'b10) begin failures++; $display("FAIL to_wait%0d got err=%b rdy=%b op=%b exp err=0 rdy=0000 op=10", c, err_o, m_rdy_o, s_op_o); end
        end
        rst_n = 1'b0;
        m_op_i = '0;
        tick();
        rst_n = 1'b1;
        checks++; if (s_op_o !== 2'b00 || m_rdy_o !== 4'b0000) begin failures++; $display("FAIL to_abandon got op=%b rdy=%b exp op=00 rdy=0000", s_op_o, m_rdy_o); end
`endif
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_stall();
        test_reset_mid_resp();
        test_rw_swap();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
